// File: rtl/mul_wb_arbiter.sv
// Writeback arbiter merging ALU and multiplier results onto one register-file port.
// Optional macro MUL_WB_BYPASS_EN lets a MUL result skip the FIFO when the port is idle.
package mul_wb_arbiter_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  dst_reg;
    logic [31:0] dst_reg_data;
    logic        reg_data_ready;
  } inst_decoded_t;
endpackage

module mul_wb_arbiter
  import mul_wb_arbiter_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  inst_decoded_t            alu_in,
  input  logic                     alu_valid,
  input  inst_decoded_t            mul_in,
  input  logic                     mul_valid,
  input  logic                     mul_issue,
  output logic                     mul_stall,
  output inst_decoded_t            wb_out,
  output logic                     wb_valid,
  output logic                     wb_src,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IF_W  = $clog2(MUL_LATENCY + DEPTH + 1);
  localparam int SUM_W = IF_W + 2;

  inst_decoded_t    mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [IF_W-1:0]  inflight, inflight_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [SUM_W-1:0] credit_sum;
  logic             empty, full;
  logic             mul_live, pop, bypass, push_req, drop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_comb begin
    // Results with no multiply in flight belong to work discarded by reset.
    mul_live = mul_valid && (inflight != '0);
    pop      = !alu_valid && !empty;
`ifdef MUL_WB_BYPASS_EN
    bypass   = !alu_valid && empty && mul_live;
`else
    bypass   = 1'b0;
`endif
    push_req = mul_live && !bypass;
    drop     = push_req && full && !pop;
    push     = push_req && !drop;

    inflight_nxt = inflight;
    if (mul_issue && !mul_live && (inflight != '1))
      inflight_nxt = inflight + IF_W'(1);
    else if (!mul_issue && mul_live)
      inflight_nxt = inflight - IF_W'(1);

    count_nxt  = buf_count + CNT_W'(push) - CNT_W'(pop);
    credit_sum = SUM_W'(inflight_nxt) + SUM_W'(count_nxt) + SUM_W'(mul_issue);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= mul_in;
  end

  // Registered writeback stage
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_out       <= '0;
      wb_valid     <= 1'b0;
      wb_src       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      buf_count    <= '0;
      inflight     <= '0;
      mul_stall    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (alu_valid) begin
        wb_out                <= alu_in;
        wb_out.reg_data_ready <= 1'b1;
        wb_valid              <= 1'b1;
        wb_src                <= 1'b0;
      end else if (pop) begin
        wb_out                <= mem[rd_ptr[PTR_W-1:0]];
        wb_out.reg_data_ready <= 1'b1;
        wb_valid              <= 1'b1;
        wb_src                <= 1'b1;
      end else if (bypass) begin
        wb_out                <= mul_in;
        wb_out.reg_data_ready <= 1'b1;
        wb_valid              <= 1'b1;
        wb_src                <= 1'b1;
      end else begin
        wb_valid <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      buf_count <= count_nxt;
      inflight  <= inflight_nxt;
      mul_stall <= (credit_sum >= SUM_W'(DEPTH));
      if (drop) overflow_err <= 1'b1;
    end
  end

endmodule
